spi_byte_slave: RTL and testbench

SPI_BYTE_SLAVE -- requirements
Module: spi_byte_slave

---
 rtl/spi_byte_slave.sv | 143 ++++++++++++++
 tb/tb_spi_byte_slave.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_byte_slave.sv
// SPI mode-0 byte slave: synchronises the SPI pins into sys_clk, receives MOSI bytes
// and shifts out bytes supplied by the command core on MISO.
module spi_byte_slave #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  IDLE_TX     = 8'hFF
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       spi_sck,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic [7:0] data_in,
  output logic       data_rdy,
  input  logic [7:0] data_out,
  input  logic       data_latch,
  output logic       frame_start,
  output logic       frame_abort,
  output logic       tx_underrun
);

  typedef enum logic {StIdle, StActive} state_e;

  state_e r_state, w_state_next;

  logic [SYNC_STAGES-1:0] r_sck_sync, r_cs_sync, r_mosi_sync;
  logic                   r_sck_d, r_cs_d;
  logic                   w_sck, w_cs_n, w_mosi;
  logic                   w_sck_rise, w_sck_fall, w_cs_rise, w_cs_fall;
  logic                   w_start, w_end, w_rise, w_fall, w_load;

  logic [2:0] r_bit_cnt;
  logic [7:0] r_rx_shift, r_data_in, r_tx_shift, r_tx_buf;
  logic       r_tx_valid, r_data_rdy, r_frame_start, r_frame_abort, r_tx_underrun;

  // Synchronisers reset to the bus idle levels so reset release creates no false edges
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_sck_sync  <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sck_d     <= 1'b0;
      r_cs_d      <= 1'b1;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], spi_sck};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      r_sck_d     <= w_sck;
      r_cs_d      <= w_cs_n;
    end
  end

  assign w_sck      = r_sck_sync[SYNC_STAGES-1];
  assign w_cs_n     = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
  assign w_sck_rise = w_sck & ~r_sck_d;
  assign w_sck_fall = ~w_sck & r_sck_d;
  assign w_cs_rise  = w_cs_n & ~r_cs_d;
  assign w_cs_fall  = ~w_cs_n & r_cs_d;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:   if (w_cs_fall) w_state_next = StActive;
      StActive: if (w_cs_rise) w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  always_comb begin
    spi_miso_oe = (r_state == StActive);
    spi_miso    = (r_state == StActive) & r_tx_shift[7];
  end

  // A CS rise in the same cycle as an SCK edge suppresses the edge
  assign w_start = (r_state == StIdle) & w_cs_fall;
  assign w_end   = (r_state == StActive) & w_cs_rise;
  assign w_rise  = (r_state == StActive) & ~w_cs_rise & w_sck_rise;
  assign w_fall  = (r_state == StActive) & ~w_cs_rise & w_sck_fall;
  // bit_cnt is 0 on a fall only after the 8th rise of a byte
  assign w_load  = w_start | (w_fall & (r_bit_cnt == 3'd0));

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt     <= 3'd0;
      r_rx_shift    <= 8'h00;
      r_data_in     <= 8'h00;
      r_data_rdy    <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_abort <= 1'b0;
    end else begin
      r_frame_start <= w_start;
      r_frame_abort <= w_end & (r_bit_cnt != 3'd0);
      r_data_rdy    <= w_rise & (r_bit_cnt == 3'd7);
      if (w_start || w_end) begin
        r_bit_cnt  <= 3'd0;
        r_rx_shift <= 8'h00;
      end else if (w_rise) begin
        r_rx_shift <= {r_rx_shift[6:0], w_mosi};
        r_bit_cnt  <= r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) r_data_in <= {r_rx_shift[6:0], w_mosi};
      end
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_tx_shift    <= 8'h00;
      r_tx_buf      <= 8'h00;
      r_tx_valid    <= 1'b0;
      r_tx_underrun <= 1'b0;
    end else begin
      if (data_latch) r_tx_buf <= data_out;
      if (w_load) begin
        r_tx_valid <= 1'b0;
        if (data_latch) begin
          r_tx_shift <= data_out;
        end else if (r_tx_valid) begin
          r_tx_shift <= r_tx_buf;
        end else begin
          r_tx_shift    <= IDLE_TX;
          r_tx_underrun <= 1'b1;
        end
      end else begin
        if (w_fall)     r_tx_shift <= {r_tx_shift[6:0], 1'b0};
        if (data_latch) r_tx_valid <= 1'b1;
      end
    end
  end

  assign data_in     = r_data_in;
  assign data_rdy    = r_data_rdy;
  assign frame_start = r_frame_start;
  assign frame_abort = r_frame_abort;
  assign tx_underrun = r_tx_underrun;

endmodule

// File: tb/tb_spi_byte_slave.sv
// Directed bench for spi_byte_slave: one instance with 2 synchroniser stages, one with 3.
module tb_spi_byte_slave;
  localparam int CLK_NS = 10;

  logic       sys_clk = 1'b0;
  logic       rst, sck, cs_n, mosi, latch;
  logic [7:0] dout;
  logic       miso, oe, rdy, fstart, fabort, undr;
  logic [7:0] din;
  logic       miso3, oe3, rdy3, fstart3, fabort3, undr3;
  logic [7:0] din3;

  always #(CLK_NS / 2) sys_clk = ~sys_clk;

  spi_byte_slave #(.SYNC_STAGES(2), .IDLE_TX(8'hFF)) dut (
    .sys_clk(sys_clk), .rst(rst), .spi_sck(sck), .spi_cs_n(cs_n), .spi_mosi(mosi),
    .spi_miso(miso), .spi_miso_oe(oe), .data_in(din), .data_rdy(rdy), .data_out(dout),
    .data_latch(latch), .frame_start(fstart), .frame_abort(fabort), .tx_underrun(undr)
  );

  spi_byte_slave #(.SYNC_STAGES(3), .IDLE_TX(8'hFF)) dut3 (
    .sys_clk(sys_clk), .rst(rst), .spi_sck(sck), .spi_cs_n(cs_n), .spi_mosi(mosi),
    .spi_miso(miso3), .spi_miso_oe(oe3), .data_in(din3), .data_rdy(rdy3), .data_out(dout),
    .data_latch(latch), .frame_start(fstart3), .frame_abort(fabort3), .tx_underrun(undr3)
  );

  int   checks = 0;
  int   errors = 0;
  int   half   = 4;
  int   rdy_hi = 0, start_cnt = 0, abort_cnt = 0;
  time  t_rise8 = 0;
  logic [7:0] rx3_q[$];
  int         lat3_q[$];

  always @(negedge sys_clk) begin
    if (rdy)    rdy_hi    <= rdy_hi + 1;
    if (fstart) start_cnt <= start_cnt + 1;
    if (fabort) abort_cnt <= abort_cnt + 1;
    if (rdy3) begin
      rx3_q.push_back(din3);
      lat3_q.push_back(int'(($time - t_rise8) / CLK_NS));
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_latch(input logic [7:0] v);
    dout  = v;
    latch = 1'b1;
    @(negedge sys_clk);
    latch = 1'b0;
    @(negedge sys_clk);
  endtask

  // Shifts nbits of b MSB first; MISO is read just before each rising edge.
  // With bypass set, data_latch is pulsed in the cycle the 2-stage DUT reloads.
  task automatic spi_bits(input logic [7:0] b, input int nbits, input bit bypass,
                          input logic [7:0] bval, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = b[7-i];
      repeat (half) @(negedge sys_clk);
      mi[7-i] = miso;
      sck = 1'b1;
      if (i == 7) t_rise8 = $time;
      repeat (half) @(negedge sys_clk);
      sck = 1'b0;
    end
    if (bypass) begin
      repeat (2) @(negedge sys_clk);
      dout  = bval;
      latch = 1'b1;
      @(negedge sys_clk);
      latch = 1'b0;
    end
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    repeat (2 * half) @(negedge sys_clk);
  endtask

  task automatic cs_high();
    repeat (half) @(negedge sys_clk);
    cs_n = 1'b1;
    repeat (2 * half + 4) @(negedge sys_clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    rst = 1'b0;
    repeat (2) @(negedge sys_clk);
  endtask

  typedef struct {
    int         n_latch;
    logic [7:0] la;
    logic [7:0] lb;
    logic [7:0] mosi_b;
    logic [7:0] exp_din;
    logic [7:0] exp_miso;
  } vec_t;

  vec_t       vecs[4];
  logic [7:0] mi, mi1;
  int         s_rdy, s_start, s_abort, n3;
  logic [7:0] exp3[3];

  initial begin
    vecs[0] = '{1, 8'hA5, 8'h00, 8'h3C, 8'h3C, 8'hA5};
    vecs[1] = '{0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF};
    vecs[2] = '{2, 8'h22, 8'h33, 8'hF0, 8'hF0, 8'h33};
    vecs[3] = '{1, 8'h80, 8'h00, 8'h01, 8'h01, 8'h80};
    exp3[0] = 8'hA1;
    exp3[1] = 8'h5C;
    exp3[2] = 8'hE7;

    rst = 1'b1; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0; latch = 1'b0; dout = 8'h00;
    repeat (3) @(negedge sys_clk);
    check("reset outputs", {26'd0, miso, oe, rdy, fstart, fabort, undr}, 32'd0);
    check("reset data_in", {24'd0, din}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge sys_clk);

    for (int v = 0; v < 4; v++) begin
      s_rdy   = rdy_hi;
      s_start = start_cnt;
      if (vecs[v].n_latch >= 1) pulse_latch(vecs[v].la);
      if (vecs[v].n_latch >= 2) pulse_latch(vecs[v].lb);
      cs_low();
      check("vec oe active", {31'd0, oe}, 32'd1);
      spi_bits(vecs[v].mosi_b, 8, 1'b0, 8'h00, mi);
      cs_high();
      check("vec data_in", {24'd0, din}, {24'd0, vecs[v].exp_din});
      check("vec miso byte", {24'd0, mi}, {24'd0, vecs[v].exp_miso});
      check("vec rdy cycles", rdy_hi - s_rdy, 32'd1);
      check("vec frame_start", start_cnt - s_start, 32'd1);
      check("vec idle miso/oe", {30'd0, miso, oe}, 32'd0);
    end

    // Three-byte frame with no transmit data
    do_reset();
    check("underrun after reset", {31'd0, undr}, 32'd0);
    s_rdy = rdy_hi;
    cs_low();
    spi_bits(8'h85, 8, 1'b0, 8'h00, mi);
    check("3byte b0 data_in", {24'd0, din}, 32'h85);
    check("3byte b0 miso", {24'd0, mi}, 32'hFF);
    spi_bits(8'h12, 8, 1'b0, 8'h00, mi);
    check("3byte b1 data_in", {24'd0, din}, 32'h12);
    check("3byte b1 miso", {24'd0, mi}, 32'hFF);
    spi_bits(8'h34, 8, 1'b0, 8'h00, mi);
    check("3byte b2 data_in", {24'd0, din}, 32'h34);
    check("3byte b2 miso", {24'd0, mi}, 32'hFF);
    cs_high();
    check("3byte rdy cycles", rdy_hi - s_rdy, 32'd3);
    check("3byte underrun", {31'd0, undr}, 32'd1);

    // Partial byte then CS rise
    s_rdy   = rdy_hi;
    s_abort = abort_cnt;
    cs_low();
    spi_bits(8'hA9, 5, 1'b0, 8'h00, mi);
    cs_high();
    check("abort pulse", abort_cnt - s_abort, 32'd1);
    check("abort no rdy", rdy_hi - s_rdy, 32'd0);
    check("abort data_in held", {24'd0, din}, 32'h34);
    cs_low();
    spi_bits(8'h7E, 8, 1'b0, 8'h00, mi);
    cs_high();
    check("post-abort data_in", {24'd0, din}, 32'h7E);
    check("post-abort rdy", rdy_hi - s_rdy, 32'd1);
    check("post-abort no 2nd abort", abort_cnt - s_abort, 32'd1);

    // data_latch coinciding with the byte-boundary reload
    do_reset();
    pulse_latch(8'h11);
    cs_low();
    spi_bits(8'h01, 8, 1'b1, 8'h5A, mi);
    check("bypass tx_valid clear", {31'd0, dut.r_tx_valid}, 32'd0);
    check("bypass no underrun", {31'd0, undr}, 32'd0);
    spi_bits(8'h02, 8, 1'b0, 8'h00, mi1);
    cs_high();
    check("bypass byte0 miso", {24'd0, mi}, 32'h11);
    check("bypass byte1 miso", {24'd0, mi1}, 32'h5A);

    // Reset in the middle of a frame
    s_rdy   = rdy_hi;
    s_abort = abort_cnt;
    cs_low();
    spi_bits(8'hF0, 4, 1'b0, 8'h00, mi);
    rst = 1'b1;
    repeat (2) @(negedge sys_clk);
    check("midrst outputs", {26'd0, miso, oe, rdy, fstart, fabort, undr}, 32'd0);
    check("midrst data_in", {24'd0, din}, 32'd0);
    cs_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    rst = 1'b0;
    s_start = start_cnt;
    repeat (8) @(negedge sys_clk);
    check("midrst no abort", abort_cnt - s_abort, 32'd0);
    check("midrst no rdy", rdy_hi - s_rdy, 32'd0);
    check("midrst no spurious start", start_cnt - s_start, 32'd0);
    cs_low();
    spi_bits(8'hC3, 8, 1'b0, 8'h00, mi);
    cs_high();
    check("post-rst data_in", {24'd0, din}, 32'hC3);
    check("post-rst frame_start", start_cnt - s_start, 32'd1);

    // Fastest SCK (sys_clk/4) into the 3-stage instance
    half = 2;
    n3   = rx3_q.size();
    cs_low();
    for (int k = 0; k < 3; k++) spi_bits(exp3[k], 8, 1'b0, 8'h00, mi);
    cs_high();
    check("sync3 byte count", rx3_q.size() - n3, 32'd3);
    for (int k = 0; k < 3; k++) begin
      if (rx3_q.size() > n3 + k) begin
        check("sync3 byte", {24'd0, rx3_q[n3+k]}, {24'd0, exp3[k]});
        check("sync3 latency in 4..6", {31'd0, (lat3_q[n3+k] >= 4 && lat3_q[n3+k] <= 6)},
              32'd1);
      end
    end
    check("sync2 fast last byte", {24'd0, din}, 32'hE7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
